// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline constants, opcodes and the fetch FIFO entry type.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam logic [31:0] BUBBLE           = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BCC   = 7'b1100011;
    localparam logic [6:0] LCC   = 7'b0000011;
    localparam logic [6:0] SCC   = 7'b0100011;
    localparam logic [6:0] MCC   = 7'b0010011;
    localparam logic [6:0] RCC   = 7'b0110011;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [6:0] CUS   = 7'b0001011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous prefetch FIFO of {pc,inst} entries; flush wins.
// Revision : 1.0
// ============================================================================
module fetch_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge CLK) begin
        if (push && !flush) r_mem[r_wr_ptr] <= din;
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Pipelined instruction fetch with prefetch FIFO, redirect flush
//            and stale-response dropping; drives the IF/ID register.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        HLT,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        IHLT,
    output logic        IREQ,
    output logic [31:0] IADDR,
    input  logic        IACK,
    input  logic [31:0] IDATA,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst
);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_tag_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic          w_redirect;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_credit_used;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    assign w_redirect    = branch_taken & ~HLT;
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_issue       = ~RES & (w_credit_used < (CW+1)'(DEPTH)) & ~w_redirect;

    // A response arriving alongside a redirect is always from the old path.
    assign w_push        = IACK & (r_drop == '0) & ~w_redirect;
    assign w_pop         = ~HLT & ~branch_taken & ~IHLT & (w_count != '0);

    assign w_push_entry.pc   = r_tag_pc;
    assign w_push_entry.inst = IDATA;

    assign IREQ  = w_issue;
    assign IADDR = r_fetch_pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RES   (RES),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_redirect),
        .din   (w_push_entry),
        .count (w_count),
        .head  (w_head)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_fetch_pc    <= RESET_PC;
            r_tag_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(IACK);

            if (w_redirect)   r_fetch_pc <= word_align(branch_target);
            else if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;

            // Everything still in flight at a redirect belongs to the old path.
            if (w_redirect)                r_drop <= r_outstanding - CW'(IACK);
            else if (IACK && r_drop != '0) r_drop <= r_drop - CW'(1);

            if (w_redirect)  r_tag_pc <= word_align(branch_target);
            else if (w_push) r_tag_pc <= r_tag_pc + 32'd4;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            IF_ID_pc   <= 32'h0;
            IF_ID_inst <= BUBBLE;
        end else if (!HLT) begin
            if (w_pop) begin
                IF_ID_pc   <= w_head.pc;
                IF_ID_inst <= w_head.inst;
            end else begin
                IF_ID_inst <= BUBBLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed bench for fetch_unit with fixed-latency memory models.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        CLK = 1'b0;
    logic        res, hlt, br, ihlt, ihlt2;
    logic [31:0] tgt;
    logic        ireq, iack, ireq2, iack2;
    logic [31:0] iaddr, idata, if_pc, if_inst;
    logic [31:0] iaddr2, idata2, if_pc2, if_inst2;

    req_t        q1[$];
    req_t        q2[$];
    int          lat1;
    int          cyc;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        o_ireq, o_ireq2;
    logic [31:0] o_iaddr, o_pc, o_inst, o_pc2, o_inst2;

    always #5 CLK = ~CLK;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) u_dut (
        .CLK(CLK), .RES(res), .HLT(hlt), .branch_taken(br), .branch_target(tgt),
        .IHLT(ihlt), .IREQ(ireq), .IADDR(iaddr), .IACK(iack), .IDATA(idata),
        .IF_ID_pc(if_pc), .IF_ID_inst(if_inst)
    );

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) u_dut2 (
        .CLK(CLK), .RES(res), .HLT(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
        .IHLT(ihlt2), .IREQ(ireq2), .IADDR(iaddr2), .IACK(iack2), .IDATA(idata2),
        .IF_ID_pc(if_pc2), .IF_ID_inst(if_inst2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1300_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Called at a falling edge with this cycle's inputs already applied.
    task automatic run_cycle();
        #1;
        o_ireq  = ireq;  o_iaddr = iaddr; o_pc  = if_pc;  o_inst  = if_inst;
        o_ireq2 = ireq2; o_pc2   = if_pc2; o_inst2 = if_inst2;
        if (ireq)  q1.push_back('{iaddr, cyc + lat1});
        if (ireq2) q2.push_back('{iaddr2, cyc + 3});
        if (q1.size() > 0 && q1[0].due == cyc) begin
            iack = 1'b1; idata = mem_word(q1[0].addr); void'(q1.pop_front());
        end else begin
            iack = 1'b0; idata = 32'h0;
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            iack2 = 1'b1; idata2 = mem_word(q2[0].addr); void'(q2.pop_front());
        end else begin
            iack2 = 1'b0; idata2 = 32'h0;
        end
        @(negedge CLK);
        cyc++;
    endtask

    task automatic do_reset();
        res = 1'b1; br = 1'b0; hlt = 1'b0; ihlt = 1'b0;
        #1;
        check("rst_ireq", ireq, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        q1.delete(); q2.delete();
        iack = 1'b0; iack2 = 1'b0; idata = 32'h0; idata2 = 32'h0;
        @(negedge CLK);
        res = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [9:0] cr_ireq;
        res = 1'b1; hlt = 1'b0; br = 1'b0; ihlt = 1'b0; ihlt2 = 1'b1; tgt = 32'h0;
        iack = 1'b0; iack2 = 1'b0; idata = 32'h0; idata2 = 32'h0;
        lat1 = 1; cyc = 0;
        cr_ireq = 10'b11_0000_0011;   // bit t = expected IREQ of DEPTH=2 unit in cycle t
        @(negedge CLK);

        // Straight line (k=1, DEPTH=4) alongside the credit-limit unit (k=3, DEPTH=2)
        do_reset();
        for (int t = 0; t < 12; t++) begin
            ihlt2 = (t < 7);
            run_cycle();
            if (t <= 8) begin
                check("sl_ireq", o_ireq, 32'h1);
                check("sl_iaddr", o_iaddr, 32'(4 * t));
            end
            if (t >= 3 && t <= 8) begin
                check("sl_pc", o_pc, 32'(4 * (t - 3)));
                check("sl_inst", o_inst, mem_word(32'(4 * (t - 3))));
            end
            if (t <= 9) check("cr_ireq", o_ireq2, 32'(cr_ireq[t]));
            if (t == 8) begin
                check("cr_pc0", o_pc2, 32'h0);
                check("cr_inst0", o_inst2, mem_word(32'h0));
            end
            if (t == 9) check("cr_pc1", o_pc2, 32'h4);
        end

        // Global hold while streaming: FIFO fills, issue stops, order kept
        do_reset();
        lat1 = 1;
        for (int t = 0; t < 17; t++) begin
            hlt = (t >= 5 && t <= 9);
            run_cycle();
            if (t >= 7 && t <= 10) check("hlt_ireq_off", o_ireq, 32'h0);
            if (t == 11) begin
                check("hlt_ireq_on", o_ireq, 32'h1);
                check("hlt_iaddr", o_iaddr, 32'd28);
            end
            if (t >= 5 && t <= 10) check("hlt_pc_frozen", o_pc, 32'h8);
            if (t >= 11) begin
                check("hlt_pc", o_pc, 32'(12 + 4 * (t - 11)));
                check("hlt_inst", o_inst, mem_word(32'(12 + 4 * (t - 11))));
            end
        end
        hlt = 1'b0;

        // Redirect with two requests in flight (k=3)
        do_reset();
        lat1 = 3;
        tgt  = 32'h100;
        for (int t = 0; t < 10; t++) begin
            br = (t == 2);
            run_cycle();
            if (t == 2) check("rd_ireq_off", o_ireq, 32'h0);
            if (t == 3) check("rd_iaddr", o_iaddr, 32'h100);
            if (t >= 3 && t <= 7) check("rd_bubble", o_inst, 32'h0);
            if (t == 8) begin
                check("rd_pc", o_pc, 32'h100);
                check("rd_inst", o_inst, mem_word(32'h100));
            end
            if (t == 9) check("rd_pc_next", o_pc, 32'h104);
        end
        br = 1'b0;

        // Redirect coinciding with an IACK, unaligned target (k=1)
        do_reset();
        lat1 = 1;
        tgt  = 32'h103;
        for (int t = 0; t < 6; t++) begin
            br = (t == 1);
            run_cycle();
            if (t == 1) check("rs_ireq_off", o_ireq, 32'h0);
            if (t == 2) check("rs_iaddr", o_iaddr, 32'h100);
            if (t >= 2 && t <= 4) check("rs_bubble", o_inst, 32'h0);
            if (t == 5) begin
                check("rs_pc", o_pc, 32'h100);
                check("rs_inst", o_inst, mem_word(32'h100));
            end
        end
        br = 1'b0;

        // Decode hold for two cycles, then redirect: wrong-path words never surface
        do_reset();
        lat1 = 1;
        tgt  = 32'h200;
        for (int t = 0; t < 12; t++) begin
            ihlt = (t == 5 || t == 6);
            br   = (t == 7);
            run_cycle();
            if (t == 5) check("ih_pc_pre", o_pc, 32'h8);
            if (t == 7) check("ih_ireq_off", o_ireq, 32'h0);
            if (t == 8) check("ih_iaddr", o_iaddr, 32'h200);
            if (t >= 6 && t <= 10) begin
                check("ih_bubble", o_inst, 32'h0);
                check("ih_pc_held", o_pc, 32'h8);
            end
            if (t == 11) begin
                check("ih_pc", o_pc, 32'h200);
                check("ih_inst", o_inst, mem_word(32'h200));
            end
        end
        ihlt = 1'b0;
        br   = 1'b0;

        // Reset mid-operation clears IF/ID immediately
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the IF/ID pipeline register consumed by the decode stage. It keeps the fetch PC and issues in-order requests to instruction memory with multiple requests in flight. Returned words are buffered in a small prefetch FIFO tagged with their PC. It handles redirects from taken branches by flushing the FIFO and discarding stale responses, and it inserts bubbles (all-zero instruction) when decode holds off for a taken branch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 4, prefetch credit.
  - Combined limit on requests in flight plus buffered entries.
  - Power of 2, at least 2.
- CLK  in  1  clock, rising edge.
- RES  in  1  reset, asynchronous and active-high.
- HLT  in  1  global pipeline hold. IF_ID outputs are frozen while it is high.
- branch_taken  in  1  redirect request from EX. Sampled only when HLT=0.
- branch_target  in  32  redirect address. Bits [1:0] are ignored and treated as 00.
- IHLT  in  1  decode has resolved a taken branch early. Fetch must not pop the FIFO.
- IREQ  out  1  request to instruction memory. One request per cycle while high; memory always accepts it.
- IADDR  out  32  request address, word aligned.
- IACK  in  1  response valid. Responses return in order, one or more cycles after their request.
- IDATA  in  32  response instruction word.
- IF_ID_pc  out  32  PC of IF_ID_inst.
- IF_ID_inst  out  32  instruction to decode. 32'h0 means bubble.

## Operation
- State:
  - fetch_pc.
  - outstanding, the count of requests not yet acknowledged.
  - drop, the count of in-flight requests whose responses must be discarded.
  - FIFO of {pc,inst}, holding count entries.
  - IF_ID registers.
- Reset values:
  - fetch_pc=RESET_PC; outstanding=drop=count=0.
  - IF_ID_pc=0, IF_ID_inst=0.
  - IREQ=0 while RES is high.
- Issue:
  - IREQ = (outstanding+count < DEPTH) & ~(branch_taken & ~HLT).
  - IADDR = fetch_pc.
  - On issue, fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
- Response:
  - On IACK, outstanding decrements.
  - If drop>0, drop decrements and the word is discarded.
  - Otherwise {pc_of_request, IDATA} is pushed. The pc comes from a tag counter that advances on every accepted non-dropped response from the redirect base.
- Pop / IF_ID update, when HLT=0:
  - branch_taken=1: IF_ID_inst <= 0, FIFO flushed, fetch_pc <= {branch_target[31:2],2'b00}, drop <= outstanding minus (1 if IACK this cycle), tag base <= target.
  - Else IHLT=1: IF_ID_inst <= 0 and no pop. Fetching and filling continue.
  - Else count>0: pop the head into IF_ID_pc/IF_ID_inst.
  - Else: IF_ID_inst <= 0.
- IF_ID_pc is held on every bubble.
- HLT=1: IF_ID is held, there is no pop, and branch_taken is ignored. Issue and response handling continue.
- An IACK in the same cycle as a redirect always belongs to the old path and is discarded.
- Push and pop in the same cycle are allowed; count is unchanged.
- Push never overflows, because the credit check guarantees space.
- A fetched word of 32'h0 is passed through unchanged; it is indistinguishable from a bubble by design.

## Timing
- Request in cycle c, IACK at c+k (k≥1): the entry is written at the end of c+k. With no bypass, the earliest IF_ID visibility is c+k+2.
- Steady-state throughput is 1 instruction/cycle when DEPTH ≥ k+2.
- Redirect in cycle r:
  - IREQ=0 in r.
  - The first request to the target is in r+1.
  - The first target instruction appears on IF_ID no earlier than r+k+3.
  - IF_ID_inst=0 from r+1 until then.
- RES asserted mid-operation clears all state immediately.
  - The first request after RES falls is in the first cycle with RES=0.
  - Responses to pre-reset requests are the memory model's responsibility (memory must also be reset).

## Structure
- Shared package pipe_pkg holds:
  - BUBBLE=32'h0.
  - Opcode constants (LUI, AUIPC, JAL, JALR, BCC, LCC, SCC, MCC, RCC, SYS, CUS).
  - The default RESET_PC.
- Sub-module fetch_fifo: synchronous FIFO of 64-bit {pc,inst} entries, DEPTH entries.
  - Signals: push, pop, flush (flush takes priority), count, head.
  - Asynchronous reset RES.

## Test plan
- Straight line, k=1, DEPTH=4: reset release → IADDR 0,4,8,… on consecutive cycles; IF_ID_pc 0,4,8 with the matching IDATA, one per cycle from cycle 3.
- Credit limit, DEPTH=2, k=3: IREQ drops after 2 requests and resumes only after a pop; outstanding+count never exceeds 2.
- Redirect with 2 requests in flight: branch_taken=1, target=32'h100 → both stale IACKs are discarded; the next IF_ID_inst≠0 has IF_ID_pc=32'h100; bubbles in between.
- Redirect in the same cycle as IACK, plus target 32'h103 → that response is dropped; IADDR=32'h100.
- HLT=1 for 5 cycles while streaming → IF_ID is constant, the FIFO fills to DEPTH, and IREQ stops; after release, in-order pops with no lost or duplicated PC.
- IHLT=1 for 2 cycles, then branch_taken → two bubbles, then the flush; buffered wrong-path words never reach IF_ID.
